// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: redirect controller state encoding and default sizes.
package mips_pipe_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned SQUASH_CYCLES = 2;
    localparam int unsigned SQ_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } bru_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken-branch evaluation for beq/bne against the ALU zero flag.
module branch_cond_eval (
    input  logic branch_eq,
    input  logic branch_ne,
    input  logic zero,
    output logic take_c
);

    assign take_c = (branch_eq & zero) | (branch_ne & ~zero);

endmodule

// File: rtl/branch_redirect_unit.sv
// Sequenced, stall-aware branch/jump redirect controller with timed flush pulses.
// Optional statistics counters enabled by defining BRANCH_REDIRECT_STATS_EN.
module branch_redirect_unit #(
    parameter int unsigned ADDR_W        = mips_pipe_pkg::ADDR_W,
    parameter int unsigned SQUASH_CYCLES = mips_pipe_pkg::SQUASH_CYCLES
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    parameter int unsigned CNT_W         = 32
`endif
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              BranchEq,
    input  logic              BranchNe,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] BranchTarget,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpTarget,
    input  logic              Stall,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] RedirectPC,
    output logic              FlushIFID,
    output logic              FlushIDEX,
    output logic              Busy
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    output logic [CNT_W-1:0]  BranchCount,
    output logic [CNT_W-1:0]  TakenCount
`endif
);

    import mips_pipe_pkg::*;

    bru_state_e          state, state_d;
    logic [SQ_CNT_W-1:0] cnt, cnt_d;
    logic [ADDR_W-1:0]   pc_d;
    logic                take_c;
    logic                pcsrc_d, flush_ifid_d, flush_idex_d, busy_d;

    branch_cond_eval u_cond (
        .branch_eq (BranchEq),
        .branch_ne (BranchNe),
        .zero      (Zero),
        .take_c    (take_c)
    );

    // State register plus registered copies of the decoded outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            RedirectPC <= '0;
            PCSrc      <= 1'b0;
            FlushIFID  <= 1'b0;
            FlushIDEX  <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            RedirectPC <= pc_d;
            PCSrc      <= pcsrc_d;
            FlushIFID  <= flush_ifid_d;
            FlushIDEX  <= flush_idex_d;
            Busy       <= busy_d;
        end
    end

    // Next state; the branch outranks the jump since the jump is younger
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pc_d    = RedirectPC;
        case (state)
            IDLE: begin
                if (take_c) begin
                    pc_d    = BranchTarget;
                    state_d = REDIRECT;
                end else if (Jump) begin
                    pc_d    = JumpTarget;
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (!Stall) begin
                    if (SQUASH_CYCLES == 1) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = SQ_CNT_W'(SQUASH_CYCLES - 1);
                        state_d = SQUASH;
                    end
                end
            end
            SQUASH: begin
                if (!Stall) begin
                    cnt_d = cnt - SQ_CNT_W'(1);
                    if (cnt == SQ_CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        pcsrc_d      = (state_d == REDIRECT);
        flush_idex_d = pcsrc_d;
        flush_ifid_d = (state_d != IDLE);
        busy_d       = flush_ifid_d;
    end

`ifdef BRANCH_REDIRECT_STATS_EN
    logic branch_seen_c;
    logic taken_go_c;

    assign branch_seen_c = (state == IDLE) & (BranchEq | BranchNe | Jump);
    assign taken_go_c    = (state == IDLE) & (state_d == REDIRECT);

    // Free-running statistics, wrapping at 2^CNT_W
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            BranchCount <= '0;
            TakenCount  <= '0;
        end else begin
            if (branch_seen_c) BranchCount <= BranchCount + CNT_W'(1);
            if (taken_go_c)    TakenCount  <= TakenCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Consumer end of the branch-decision path. Takes the raw branch condition (Branch/Zero from EX/MEM, Jump from ID) and turns it into a registered PC redirect plus timed flush pulses for the younger pipeline registers.
- Sits between the EX/MEM pipeline register and the PC mux / IF-ID / ID-EX register clears.
- Replaces the combinational Branch-and-Zero gating with a small sequenced controller that is stall-aware.

Parameters:
- ADDR_W, 32, PC / target address width.
- SQUASH_CYCLES, 2, number of cycles FlushIFID stays asserted after a redirect is accepted. Legal range 1..7.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- Clk  in  1  pipeline clock.
- Rst  in  1  asynchronous, active-low reset.
- BranchEq  in  1  EX/MEM: instruction is beq.
- BranchNe  in  1  EX/MEM: instruction is bne.
- Zero  in  1  EX/MEM: ALU zero flag.
- BranchTarget  in  ADDR_W  EX/MEM: computed branch target.
- Jump  in  1  ID: instruction is j/jal.
- JumpTarget  in  ADDR_W  ID: jump target.
- Stall  in  1  hazard unit: PC and IF/ID are frozen this cycle.
- PCSrc  out  1  select RedirectPC at the PC mux.
- RedirectPC  out  ADDR_W  redirect address.
- FlushIFID  out  1  clear the IF/ID register.
- FlushIDEX  out  1  clear the ID/EX register.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE; PCSrc, FlushIFID, FlushIDEX, Busy = 0; RedirectPC = 0; squash counter = 0.
- Taken branch: take = (BranchEq & Zero) | (BranchNe & ~Zero). Sampled only in IDLE.
- States:
  - IDLE.
  - REDIRECT: PCSrc=1, FlushIFID=1, FlushIDEX=1, Busy=1.
  - SQUASH: PCSrc=0, FlushIFID=1, FlushIDEX=0, Busy=1.
- IDLE with take=1: latch BranchTarget into RedirectPC, go to REDIRECT at the next edge. Latency is 1 cycle from the sampled condition to PCSrc.
- IDLE with take=0 and Jump=1: latch JumpTarget and go to REDIRECT.
- Simultaneous take and Jump: the branch wins and the jump is dropped, because the jump belongs to a younger, squashed instruction.
- REDIRECT with Stall=1: hold REDIRECT. All outputs and RedirectPC stay unchanged until a cycle with Stall=0.
- REDIRECT with Stall=0: the redirect is accepted.
  - If SQUASH_CYCLES=1, go to IDLE.
  - Otherwise load counter=SQUASH_CYCLES-1 and go to SQUASH.
- SQUASH:
  - Decrement the counter on each cycle with Stall=0. Stall freezes the counter.
  - Go to IDLE when the counter reaches 1 and Stall=0 on that cycle.
- Branch or jump inputs arriving in REDIRECT or SQUASH are ignored; they belong to squashed instructions.
- RedirectPC holds its last value in IDLE. It is only meaningful while PCSrc=1.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. No redirect is replayed.
- Back-to-back branches: a taken branch sampled in the first IDLE cycle after SQUASH is honoured normally.

Optional Feature:
- Macro: BRANCH_REDIRECT_STATS_EN.
- Defined:
  - Adds outputs BranchCount [CNT_W] and TakenCount [CNT_W].
  - BranchCount increments when any of BranchEq, BranchNe or Jump is sampled in IDLE.
  - TakenCount increments on each IDLE→REDIRECT transition.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package `mips_pipe_pkg`:
  - State encoding typedef with values IDLE=2'd0, REDIRECT=2'd1, SQUASH=2'd2.
  - Constants ADDR_W and the default SQUASH_CYCLES.
- One sub-module is natural: `branch_cond_eval`, the combinational take logic. It is reused by a future early-resolve-in-ID variant.
- The FSM and counter stay in the top module.

Test Plan:
- Reset, then BranchEq=1, Zero=1, BranchTarget=0x00400040 → next cycle PCSrc=1, RedirectPC=0x00400040, FlushIFID=FlushIDEX=1. Then FlushIFID=1 alone for 1 cycle (SQUASH_CYCLES=2), then IDLE with all outputs 0.
- BranchNe=1, Zero=1 → no redirect and Busy stays 0. BranchNe=1, Zero=0 → redirect exactly as above.
- Taken branch plus Stall=1 held for 3 cycles in REDIRECT → PCSrc held for 4 cycles total, then SQUASH proceeds unchanged.
- In the same cycle BranchEq=1, Zero=1, target 0x100 and Jump=1, target 0x200 → RedirectPC=0x100.
- Jump=1, JumpTarget=0x00400100 while in SQUASH → ignored. The same jump sampled in IDLE → redirect to 0x00400100.
- Rst pulled low during REDIRECT → all outputs 0 asynchronously. After release, IDLE and no PCSrc.
- With BRANCH_REDIRECT_STATS_EN defined: 5 branches, 3 taken → BranchCount=5, TakenCount=3.
